seq_pattern_det: RTL and testbench

- Parametrised serial pattern detector. Successor to the single-pattern, fixed-length, single-bit-input demo detector.
- Samples a qualified serial bit stream and compares the newest bits against a programmable, maskable pattern of runtime-selectable length.
- Emits a one-cycle registered match pulse and keeps a saturating match count.
- Overlapping or non-overlapping detection is selectable; the block sits between a serial front end and status logic.

---
 rtl/seq_pattern_det_pkg.sv | 24 ++
 rtl/sat_counter.sv | 33 +++
 rtl/seq_pattern_det.sv | 105 ++++++++++
 tb/tb_seq_pattern_det.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_det_pkg.sv
// Shared definitions for the serial pattern detector: state encoding and
// helpers that turn the runtime length configuration into a compare mask.
package seq_pattern_det_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  // Ones in bits [len-1:0]; callers slice the low MAX_LEN bits (MAX_LEN <= 32).
  function automatic logic [31:0] len_mask(input int unsigned len);
    logic [31:0] m;
    for (int unsigned i = 0; i < 32; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

  // Out-of-range lengths (0 or above the maximum) select the full pattern.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return ((len == 0) || (len > max_len)) ? max_len : len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;

  // Next count: clear first, then increment unless already at all-ones.
  always_comb begin
    q_d = q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q != '1)) begin
      q_d = q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/seq_pattern_det.sv
// Serial pattern detector: shifts qualified bits into a history register and
// compares the newest L bits against a maskable pattern, pulsing w on a match.
module seq_pattern_det
  import seq_pattern_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               a,
  input  logic               a_vld,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [MAX_LEN-1:0] cfg_mask,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               w,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  // Only MAX_LEN-1 older bits are stored; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] hist_new;
  logic [MAX_LEN-1:0] eff_mask;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
  logic [LEN_W-1:0]   eff_len;
  logic [1:0]         state_q, state_d;
  logic               sample;
  logic               evaluate;
  logic               match;
  logic               w_q;

  // Sample qualification, window assembly and match decision.
  always_comb begin
    sample   = en & a_vld;
    hist_new = {hist_q, a};
    eff_len  = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
    eff_mask = cfg_mask & MAX_LEN'(len_mask(32'(eff_len)));
    fill_inc = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    evaluate = sample && (fill_inc >= eff_len);
    match    = evaluate && (((hist_new ^ cfg_pat) & eff_mask) == '0);
  end

  // FSM and history next state; en low forces IDLE and wipes the history.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    state_d = state_q;
    if (!en) begin
      hist_d  = '0;
      fill_d  = '0;
      state_d = IDLE;
    end else begin
      if (state_q == IDLE) begin
        state_d = FILL;
      end
      if (sample) begin
        hist_d  = hist_new[MAX_LEN-2:0];
        fill_d  = fill_inc;
        state_d = evaluate ? RUN : FILL;
        // Non-overlapping: the next match must be built from fresh samples.
        if (match && !cfg_overlap) begin
          fill_d  = '0;
          state_d = FILL;
        end
      end
    end
  end

  // State, history and match pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= IDLE;
      w_q     <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      w_q     <= match;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (match),
    .q     (match_cnt)
  );

  // Output mapping.
  always_comb begin
    w     = w_q;
    armed = (state_q == RUN);
  end

endmodule

// File: tb/tb_seq_pattern_det.sv
// Self-checking bench for seq_pattern_det: directed scenarios plus a random
// run, all compared against a window/queue based reference model.
module tb_seq_pattern_det;

  localparam int unsigned MaxLen = 8;
  localparam int unsigned CntMax = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, a, a_vld, cnt_clr, cfg_overlap;
  logic [7:0] cfg_pat, cfg_mask;
  logic [3:0] cfg_len;
  logic       w, armed;
  logic [2:0] match_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state: newest sample at index 0.
  int hist_m[$];
  int fresh;
  int exp_cnt;

  seq_pattern_det #(
    .MAX_LEN (8),
    .LEN_W   (4),
    .CNT_W   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .a           (a),
    .a_vld       (a_vld),
    .cfg_pat     (cfg_pat),
    .cfg_mask    (cfg_mask),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .w           (w),
    .match_cnt   (match_cnt),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int eff_len_m();
    return ((cfg_len == 0) || (cfg_len > MaxLen)) ? MaxLen : int'(cfg_len);
  endfunction

  task automatic model_reset();
    hist_m.delete();
    fresh   = 0;
    exp_cnt = 0;
  endtask

  // One clock: drive inputs, predict, then check all outputs after the edge.
  task automatic step(input logic e, input logic b, input logic v, input logic c,
                      input string tag);
    int  len;
    bit  m;
    en      = e;
    a       = b;
    a_vld   = v;
    cnt_clr = c;
    len     = eff_len_m();
    m       = 1'b0;
    if (!e) begin
      hist_m.delete();
      fresh = 0;
    end else if (v) begin
      hist_m.push_front(int'(b));
      if (hist_m.size() > MaxLen) void'(hist_m.pop_back());
      if (fresh < MaxLen) fresh++;
      if (fresh >= len) begin
        m = 1'b1;
        for (int i = 0; i < len; i++) begin
          if (cfg_mask[i] && (cfg_pat[i] != hist_m[i][0])) m = 1'b0;
        end
      end
      if (m && !cfg_overlap) fresh = 0;
    end
    if (c) exp_cnt = 0;
    else if (m && (exp_cnt < CntMax)) exp_cnt++;
    @(posedge clk);
    #1;
    chk({tag, ".w"}, 32'(w), 32'(m));
    chk({tag, ".cnt"}, 32'(match_cnt), 32'(exp_cnt));
    chk({tag, ".armed"}, 32'(armed), 32'(e && (fresh >= len)));
  endtask

  task automatic set_cfg(input logic [3:0] len, input logic [7:0] pat, input logic [7:0] msk,
                         input logic ovl);
    cfg_len     = len;
    cfg_pat     = pat;
    cfg_mask    = msk;
    cfg_overlap = ovl;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".w"}, 32'(w), 0);
    chk({tag, ".cnt"}, 32'(match_cnt), 0);
    chk({tag, ".armed"}, 32'(armed), 0);
  endtask

  initial begin
    logic [7:0] byte_v;
    rst_n = 1'b0;
    en = 0; a = 0; a_vld = 0; cnt_clr = 0;
    set_cfg(4'd3, 8'b101, 8'hFF, 1'b1);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: stream, then asynchronous reset mid-stream, then idle with toggling a.
    step(1, 0, 0, 0, "t1.en");
    step(1, 1, 1, 0, "t1.s0");
    step(1, 0, 1, 0, "t1.s1");
    step(1, 1, 1, 0, "t1.s2");
    en = 1; a = 0; a_vld = 1;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_zero("t1.rst_async");
    repeat (3) @(posedge clk);
    #1;
    chk_zero("t1.rst_hold");
    en = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(0, i[0], 1, 0, "t1.idle");

    // 2: overlapping 101.
    step(1, 0, 0, 0, "t2.en");
    step(1, 1, 1, 0, "t2.s0");
    step(1, 0, 1, 0, "t2.s1");
    step(1, 1, 1, 0, "t2.s2");
    chk("t2.third_w", 32'(w), 1);
    step(1, 0, 1, 0, "t2.s3");
    step(1, 1, 1, 0, "t2.s4");
    chk("t2.cnt2", 32'(match_cnt), 2);

    // 3: non-overlapping 101 then 0,1 for a second fresh match.
    step(0, 0, 0, 0, "t3.off");
    set_cfg(4'd3, 8'b101, 8'hFF, 1'b0);
    step(1, 0, 0, 1, "t3.clr");
    step(1, 1, 1, 0, "t3.s0");
    step(1, 0, 1, 0, "t3.s1");
    step(1, 1, 1, 0, "t3.s2");
    step(1, 0, 1, 0, "t3.s3");
    step(1, 1, 1, 0, "t3.s4");
    chk("t3.cnt1", 32'(match_cnt), 1);
    step(1, 0, 1, 0, "t3.s5");
    step(1, 1, 1, 0, "t3.s6");
    chk("t3.w2", 32'(w), 1);

    // 4: clamped length, masked upper nibble, random gaps.
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, "t4.off");
      set_cfg(4'd0, 8'hA5, 8'h0F, 1'b1);
      step(1, 0, 0, 1, "t4.clr");
      byte_v = {4'($urandom), (k == 3) ? 4'h4 : 4'h5};
      for (int b = 7; b >= 0; b--) begin
        repeat ($urandom_range(0, 2)) step(1, 1'($urandom), 0, 0, "t4.gap");
        step(1, byte_v[b], 1, 0, "t4.bit");
      end
      chk("t4.final_w", 32'(w), (k == 3) ? 0 : 1);
    end

    // 5: saturation at 7, then clear racing a matching sample.
    step(0, 0, 0, 0, "t5.off");
    set_cfg(4'd1, 8'h01, 8'h01, 1'b1);
    step(1, 0, 0, 1, "t5.clr");
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, "t5.one");
    chk("t5.sat", 32'(match_cnt), 7);
    step(1, 1, 1, 1, "t5.clr_match");
    chk("t5.clr_w", 32'(w), 1);
    chk("t5.clr_cnt", 32'(match_cnt), 0);

    // 6: enable drop after two of three bits forces a full restart.
    step(0, 0, 0, 0, "t6.off");
    set_cfg(4'd3, 8'b101, 8'hFF, 1'b1);
    step(1, 0, 0, 1, "t6.clr");
    step(1, 1, 1, 0, "t6.s0");
    step(1, 0, 1, 0, "t6.s1");
    step(0, 1, 1, 0, "t6.drop");
    step(1, 0, 0, 0, "t6.reen");
    step(1, 1, 1, 0, "t6.s2");
    chk("t6.no_match", 32'(w), 0);
    step(1, 0, 1, 0, "t6.s3");
    step(1, 1, 1, 0, "t6.s4");

    // Random traffic with config changes only while disabled.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        set_cfg(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom));
        step(0, 1'($urandom), 1'($urandom), 1'b0, "rnd.cfg");
      end else begin
        step($urandom_range(0, 19) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
             $urandom_range(0, 49) == 0, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
